// File: rtl/uart_pkg.sv
// Shared UART receiver definitions: one-hot FSM states, parity modes, vote helper.
package uart_pkg;
  localparam int MIN_DATA_WD = 5;

  typedef enum logic [6:0] {
    ST_IDLE   = 7'b0000001,
    ST_START  = 7'b0000010,
    ST_DATA   = 7'b0000100,
    ST_PARITY = 7'b0001000,
    ST_STOP1  = 7'b0010000,
    ST_STOP2  = 7'b0100000,
    ST_BREAK  = 7'b1000000
  } rx_state_t;

  typedef enum logic [1:0] {
    PAR_NONE  = 2'd0,
    PAR_ODD   = 2'd1,
    PAR_EVEN  = 2'd2,
    PAR_NONE3 = 2'd3
  } par_mode_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO; head is presented combinationally, 0 when empty.
module uart_rx_fifo #(
  parameter int W     = 11,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [W-1:0]                 din,
  input  logic                         pop,
  output logic [W-1:0]                 dout,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // a full FIFO still accepts a write when the head leaves in the same cycle
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 3-sample vote, glitch/break handling, tagged FWFT receive FIFO.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int MAX_DATA_WD       = 9,
  parameter int oversampling_rate = 16,
  parameter int FIFO_DEPTH        = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            rx,
  input  logic                            tick,
  input  logic                            rx_en,
  input  logic [3:0]                      cfg_data_wd,
  input  logic [1:0]                      cfg_parity,
  input  logic                            cfg_stop2,
  input  logic                            rd_en,
  input  logic                            clr_ovr,
  output logic [MAX_DATA_WD-1:0]          dout,
  output logic                            dout_pe,
  output logic                            dout_fe,
  output logic                            rx_valid,
  output logic                            fifo_full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                            rx_busy,
  output logic                            overrun_flag,
  output logic                            break_flag
);
  localparam int OS = oversampling_rate;
  localparam int CW = $clog2(OS);
  localparam logic [CW-1:0] V0    = CW'(OS/2 - 1);
  localparam logic [CW-1:0] V1    = CW'(OS/2);
  localparam logic [CW-1:0] V2    = CW'(OS/2 + 1);
  localparam logic [CW-1:0] C_END = CW'(OS - 1);
  localparam logic [3:0] WD_MIN = 4'(MIN_DATA_WD);
  localparam logic [3:0] WD_MAX = 4'(MAX_DATA_WD);

  typedef struct packed {
    logic [MAX_DATA_WD-1:0] data;
    logic                   pe;
    logic                   fe;
  } rx_entry_t;

  rx_state_t              state_q, state_d;
  logic [1:0]             sync_q;
  logic                   rx_s, rx_prev, fall;
  logic [CW-1:0]          tcnt;
  logic                   samp_a, samp_b, vote;
  logic [3:0]             bit_idx, wd_q, wd_eff;
  logic [MAX_DATA_WD-1:0] shreg;
  par_mode_t              par_q;
  logic                   stop2_q, pbit_q, pe_q, stop1_q, brk_q, ovr_q;
  logic                   in_frame, at_vote, at_end, par_en, par_x;
  logic                   data_zero, pbit_zero;
  logic                   start_frame, push, push_fe, set_brk, clr_brk, overrun;
  rx_entry_t              push_ent, head;
  logic                   fifo_empty;

  // rx idles high, so the synchroniser and edge history preset to 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      sync_q  <= {sync_q[0], rx};
      rx_prev <= rx_s;
    end
  end
  assign rx_s = sync_q[1];
  assign fall = rx_prev & ~rx_s;

  assign wd_eff    = (cfg_data_wd < WD_MIN) ? WD_MIN :
                     (cfg_data_wd > WD_MAX) ? WD_MAX : cfg_data_wd;
  assign in_frame  = (state_q != ST_IDLE) && (state_q != ST_BREAK);
  assign at_vote   = tick && in_frame && (tcnt == V2);
  assign at_end    = tick && in_frame && (tcnt == C_END);
  assign vote      = maj3(samp_a, samp_b, rx_s);
  assign par_en    = (par_q == PAR_ODD) || (par_q == PAR_EVEN);
  assign par_x     = (^shreg) ^ vote;
  assign data_zero = (shreg == '0);
  assign pbit_zero = !par_en || !pbit_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    start_frame = 1'b0;
    push        = 1'b0;
    push_fe     = 1'b0;
    set_brk     = 1'b0;
    clr_brk     = 1'b0;
    unique case (state_q)
      ST_IDLE: if (rx_en && fall) begin
        start_frame = 1'b1;
        state_d     = ST_START;
      end
      ST_START: begin
        if (at_vote && vote) state_d = ST_IDLE;
        else if (at_end)     state_d = ST_DATA;
      end
      ST_DATA: if (at_end && (bit_idx == wd_q - 1'b1))
        state_d = par_en ? ST_PARITY : ST_STOP1;
      ST_PARITY: if (at_end) state_d = ST_STOP1;
      // leaving at the vote rather than the bit end gives half a bit of resync margin
      ST_STOP1: begin
        if (at_vote && !stop2_q) begin
          push    = 1'b1;
          push_fe = !vote;
          if (data_zero && pbit_zero && !vote) begin
            set_brk = 1'b1;
            state_d = ST_BREAK;
          end else state_d = ST_IDLE;
        end else if (at_end) state_d = ST_STOP2;
      end
      ST_STOP2: if (at_vote) begin
        push    = 1'b1;
        push_fe = !stop1_q || !vote;
        if (data_zero && pbit_zero && !stop1_q && !vote) begin
          set_brk = 1'b1;
          state_d = ST_BREAK;
        end else state_d = ST_IDLE;
      end
      ST_BREAK: if (rx_s) begin
        clr_brk = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt    <= '0;
      samp_a  <= 1'b1;
      samp_b  <= 1'b1;
      bit_idx <= '0;
      shreg   <= '0;
      wd_q    <= WD_MIN;
      par_q   <= PAR_NONE;
      stop2_q <= 1'b0;
      pbit_q  <= 1'b0;
      pe_q    <= 1'b0;
      stop1_q <= 1'b1;
    end else if (start_frame) begin
      tcnt    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      wd_q    <= wd_eff;
      par_q   <= par_mode_t'(cfg_parity);
      stop2_q <= cfg_stop2;
      pbit_q  <= 1'b0;
      pe_q    <= 1'b0;
      stop1_q <= 1'b1;
    end else if (tick && in_frame) begin
      tcnt <= (tcnt == C_END) ? '0 : tcnt + 1'b1;
      if (tcnt == V0) samp_a <= rx_s;
      if (tcnt == V1) samp_b <= rx_s;
      if (at_vote && state_q == ST_DATA)
        shreg <= shreg | (MAX_DATA_WD'(vote) << bit_idx);
      if (at_vote && state_q == ST_PARITY) begin
        pbit_q <= vote;
        pe_q   <= (par_q == PAR_ODD) ? ~par_x : par_x;
      end
      if (at_vote && state_q == ST_STOP1) stop1_q <= vote;
      if (at_end && state_q == ST_DATA) bit_idx <= bit_idx + 1'b1;
    end
  end

  // a simultaneous overrun wins over clr_ovr
  assign overrun = push && fifo_full && !rd_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      brk_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      if (set_brk)      brk_q <= 1'b1;
      else if (clr_brk) brk_q <= 1'b0;
      if (overrun)      ovr_q <= 1'b1;
      else if (clr_ovr) ovr_q <= 1'b0;
    end
  end

  assign push_ent = '{data: shreg, pe: pe_q, fe: push_fe};

  uart_rx_fifo #(
    .W     (MAX_DATA_WD + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (push_ent),
    .pop   (rd_en),
    .dout  (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign dout         = head.data;
  assign dout_pe      = head.pe;
  assign dout_fe      = head.fe;
  assign rx_valid     = !fifo_empty;
  assign rx_busy      = (state_q != ST_IDLE);
  assign overrun_flag = ovr_q;
  assign break_flag   = brk_q;
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: serial frames in, tagged FIFO entries checked out.
module tb_uart_rx_cfg;
  logic       clk = 1'b0;
  logic       rst_n, rx, tick, rx_en, cfg_stop2, rd_en, clr_ovr;
  logic [3:0] cfg_data_wd;
  logic [1:0] cfg_parity;
  logic [8:0] dout;
  logic       dout_pe, dout_fe, rx_valid, fifo_full, rx_busy, overrun_flag, break_flag;
  logic [2:0] fifo_count;

  int n_tot = 0;
  int n_bad = 0;
  logic [10:0] q[$];

  uart_rx_cfg #(.MAX_DATA_WD(9), .oversampling_rate(16), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .tick(tick), .rx_en(rx_en),
    .cfg_data_wd(cfg_data_wd), .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
    .rd_en(rd_en), .clr_ovr(clr_ovr), .dout(dout), .dout_pe(dout_pe), .dout_fe(dout_fe),
    .rx_valid(rx_valid), .fifo_full(fifo_full), .fifo_count(fifo_count), .rx_busy(rx_busy),
    .overrun_flag(overrun_flag), .break_flag(break_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    cyc(16);
  endtask

  task automatic send_frame(input logic [8:0] d, input int wd, input int par, input bit pflip,
                            input bit st1, input bit st2, input bit two, input bit exp_push,
                            input int idle);
    logic [8:0] m;
    logic       p, fe;
    cfg_data_wd = 4'(wd);
    cfg_parity  = 2'(par);
    cfg_stop2   = two;
    m  = d & ((9'h1 << wd) - 9'h1);
    fe = !st1 || (two && !st2);
    send_bit(1'b0);
    for (int i = 0; i < wd; i++) send_bit(m[i]);
    if (par == 1 || par == 2) begin
      p = (^m) ^ (par == 1);
      send_bit(p ^ pflip);
    end
    send_bit(st1);
    if (two) send_bit(st2);
    rx = 1'b1;
    if (exp_push) q.push_back({m, pflip && (par == 1 || par == 2), fe});
    cyc(idle);
  endtask

  task automatic pop_chk(input string tag);
    logic [10:0] e;
    int n;
    n = 0;
    while (!rx_valid && n < 400) begin cyc(1); n++; end
    chk({tag, "_vld"}, rx_valid, 1);
    chk({tag, "_sb"}, q.size() != 0, 1);
    if (q.size() != 0) begin
      e = q.pop_front();
      chk({tag, "_d"},  dout,    e[10:2]);
      chk({tag, "_pe"}, dout_pe, e[1]);
      chk({tag, "_fe"}, dout_fe, e[0]);
    end
    rd_en = 1'b1;
    cyc(1);
    rd_en = 1'b0;
  endtask

  task automatic out_chk(input string tag);
    chk({tag, "_dout"}, dout, 0);
    chk({tag, "_pe"},   dout_pe, 0);
    chk({tag, "_fe"},   dout_fe, 0);
    chk({tag, "_vld"},  rx_valid, 0);
    chk({tag, "_full"}, fifo_full, 0);
    chk({tag, "_cnt"},  fifo_count, 0);
    chk({tag, "_busy"}, rx_busy, 0);
    chk({tag, "_ovr"},  overrun_flag, 0);
    chk({tag, "_brk"},  break_flag, 0);
  endtask

  initial begin
    logic saw;
    rst_n = 1'b0; rx = 1'b1; tick = 1'b1; rx_en = 1'b1;
    cfg_data_wd = 4'd8; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
    rd_en = 1'b0; clr_ovr = 1'b0;
    cyc(3);
    out_chk("rst");
    rst_n = 1'b1;
    cyc(4);

    // 8N1 basic
    send_frame(9'hA5, 8, 0, 0, 1, 1, 0, 1, 16);
    pop_chk("a5");
    chk("a5_empty", rx_valid, 0);
    chk("a5_cnt", fifo_count, 0);

    // 7E1 with wrong parity bit
    send_frame(9'h35, 7, 2, 1, 1, 1, 0, 1, 16);
    pop_chk("7e1");

    // start glitch
    saw = 1'b0;
    rx = 1'b0;
    repeat (4) begin cyc(1); saw |= rx_busy; end
    rx = 1'b1;
    repeat (30) begin cyc(1); saw |= rx_busy; end
    chk("gl_busy_seen", saw, 1);
    chk("gl_busy", rx_busy, 0);
    chk("gl_vld", rx_valid, 0);
    chk("gl_brk", break_flag, 0);

    // framing error
    send_frame(9'h55, 8, 0, 0, 0, 1, 0, 1, 16);
    pop_chk("fe");

    // break: low for three 8N1 frame times
    cfg_data_wd = 4'd8; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
    rx = 1'b0;
    cyc(480);
    q.push_back({9'h000, 1'b0, 1'b1});
    chk("brk_flag", break_flag, 1);
    chk("brk_busy", rx_busy, 1);
    chk("brk_cnt", fifo_count, 1);
    rx = 1'b1;
    cyc(6);
    chk("brk_clr", break_flag, 0);
    chk("brk_idle", rx_busy, 0);
    pop_chk("brk");
    cyc(40);
    chk("brk_nomore", fifo_count, 0);

    // overrun with depth 4
    for (int i = 1; i <= 5; i++) send_frame(9'(i), 8, 0, 0, 1, 1, 0, i <= 4, 16);
    chk("ovr_cnt", fifo_count, 4);
    chk("ovr_full", fifo_full, 1);
    chk("ovr_flag", overrun_flag, 1);
    clr_ovr = 1'b1;
    cyc(1);
    clr_ovr = 1'b0;
    chk("ovr_clr", overrun_flag, 0);
    for (int i = 1; i <= 4; i++) pop_chk($sformatf("ovr%0d", i));
    chk("ovr_empty", rx_valid, 0);

    // 9E2 back-to-back
    send_frame(9'h1FF, 9, 2, 0, 1, 1, 1, 1, 0);
    send_frame(9'h1FF, 9, 2, 0, 1, 1, 1, 1, 16);
    chk("9e2_cnt", fifo_count, 2);
    pop_chk("9e2a");
    pop_chk("9e2b");

    // reset mid-DATA with a stored entry
    send_frame(9'h3C, 8, 0, 0, 1, 1, 0, 1, 16);
    chk("mid_vld", rx_valid, 1);
    rx = 1'b0; cyc(16);
    rx = 1'b1; cyc(16);
    rx = 1'b0; cyc(8);
    chk("mid_busy", rx_busy, 1);
    rx = 1'b1;
    rst_n = 1'b0;
    #1;
    out_chk("mid");
    q.delete();
    cyc(2);
    rst_n = 1'b1;
    cyc(20);
    out_chk("post");

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1);
  end
endmodule
